// File: rtl/drlp_pkg.sv
// Shared types for the DRLP DMA scheduler: FSM state encoding and the packet request record.
package drlp_pkg;

    // Request fields are sized for the widest supported configuration; unused upper bits stay zero.
    localparam int unsigned drlp_addr_max_c = 32;
    localparam int unsigned drlp_data_max_c = 64;

    typedef enum logic [1:0] {
        DRLP_IDLE  = 2'd0,
        DRLP_RUN   = 2'd1,
        DRLP_DRAIN = 2'd2,
        DRLP_DONE  = 2'd3
    } drlp_dma_state_e;

    typedef struct packed {
        logic                       we;
        logic [drlp_addr_max_c-1:0] addr;
        logic [drlp_data_max_c-1:0] data;
    } drlp_dma_req_s;

endpackage

// File: rtl/drlp_dma_wr_fifo.sv
// Write buffer for the DRLP DMA scheduler: 1R1W FIFO with a combinational head and
// simultaneous push/pop allowed when full.
module drlp_dma_wr_fifo #(
    parameter int width_p = 35,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    typedef logic [ptr_w_lp:0] ptr_t;

    ptr_t               wr_ptr_reg;
    ptr_t               rd_ptr_reg;
    logic [width_p-1:0] mem_reg [els_p];
    logic               push;
    logic               pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[ptr_w_lp] != rd_ptr_reg[ptr_w_lp]) &&
                     (wr_ptr_reg[ptr_w_lp-1:0] == rd_ptr_reg[ptr_w_lp-1:0]);
    assign v_o     = ~empty_o;
    assign data_o  = mem_reg[rd_ptr_reg[ptr_w_lp-1:0]];

    assign pop  = yumi_i & ~empty_o;
    assign push = v_i & (~full_o | pop);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg[ptr_w_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/drlp_dma_sched.sv
// DRLP DMA scheduler: round-robin between direct reads and buffered writes, credit-limited
// launch, flush/drain FSM. Define DRLP_DMA_SCHED_STATS_EN to add launch counters.
module drlp_dma_sched
    import drlp_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 3,
    parameter int max_out_credits_p = 16,
    parameter int wr_fifo_els_p     = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       rd_v_i,
    input  logic [addr_width_p-1:0]                    rd_addr_i,
    output logic                                       rd_ready_o,
    input  logic                                       wr_v_i,
    input  logic [addr_width_p-1:0]                    wr_addr_i,
    input  logic [data_width_p-1:0]                    wr_data_i,
    output logic                                       wr_ready_o,
    output logic                                       out_v_o,
    output logic                                       out_we_o,
    output logic [addr_width_p-1:0]                    out_addr_o,
    output logic [data_width_p-1:0]                    out_data_o,
    input  logic                                       out_ready_i,
    input  logic                                       credit_return_i,
    input  logic                                       flush_i,
    output logic                                       done_o,
    output logic [$clog2(max_out_credits_p+1)-1:0]     credits_o
`ifdef DRLP_DMA_SCHED_STATS_EN
    ,
    output logic [31:0]                                rd_cnt_o,
    output logic [31:0]                                wr_cnt_o
`endif
);

    localparam int cred_w_lp = $clog2(max_out_credits_p + 1);
    localparam logic [cred_w_lp-1:0] max_cred_lp = cred_w_lp'(max_out_credits_p);

    drlp_dma_state_e        state_reg;
    logic                   done_reg;
    logic [cred_w_lp-1:0]   credits_reg, credits_next;
    logic                   last_rd_reg;
    logic                   hold_reg, hold_rd_reg;

    logic                   fifo_v, fifo_full, fifo_empty, fifo_yumi, fifo_push;
    logic [addr_width_p+data_width_p-1:0] fifo_data;
    logic [addr_width_p-1:0] head_addr;
    logic [data_width_p-1:0] head_data;

    logic serve_rd, accept_wr, rd_req, wr_req, credit_avail;
    logic grant_rd, out_v, launch, ret_eff;
    drlp_dma_req_s out_req;
    logic unused_req;

    assign serve_rd  = (state_reg == DRLP_IDLE) || (state_reg == DRLP_RUN);
    assign accept_wr = serve_rd & ~reset_i;

    assign wr_ready_o = accept_wr & (~fifo_full | fifo_yumi);
    assign fifo_push  = wr_v_i & wr_ready_o;

    drlp_dma_wr_fifo #(
        .width_p (addr_width_p + data_width_p),
        .els_p   (wr_fifo_els_p)
    ) wr_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_push),
        .data_i  ({wr_addr_i, wr_data_i}),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_addr, head_data} = fifo_data;

    // Requests are masked during reset so nothing launches from stale buffered state.
    assign rd_req       = rd_v_i & serve_rd & ~reset_i;
    assign wr_req       = fifo_v & ~reset_i;
    assign credit_avail = credits_reg < max_cred_lp;

    // A presented-but-stalled packet keeps its grant so its fields remain stable.
    always_comb begin
        grant_rd = 1'b0;
        if (hold_reg && (hold_rd_reg ? rd_req : wr_req)) begin
            grant_rd = hold_rd_reg;
        end else if (rd_req && wr_req) begin
            grant_rd = ~last_rd_reg;
        end else begin
            grant_rd = rd_req;
        end
    end

    assign out_v      = (rd_req | wr_req) & credit_avail;
    assign launch     = out_v & out_ready_i;
    assign rd_ready_o = launch & grant_rd;
    assign fifo_yumi  = launch & ~grant_rd;

    always_comb begin
        out_req = '0;
        if (grant_rd) begin
            out_req.we                     = 1'b0;
            out_req.addr[addr_width_p-1:0] = rd_addr_i;
        end else begin
            out_req.we                     = 1'b1;
            out_req.addr[addr_width_p-1:0] = head_addr;
            out_req.data[data_width_p-1:0] = head_data;
        end
    end

    assign unused_req = ^out_req;
    assign out_v_o    = out_v;
    assign out_we_o   = out_req.we;
    assign out_addr_o = out_req.addr[addr_width_p-1:0];
    assign out_data_o = out_req.data[data_width_p-1:0];

    // A return with nothing outstanding is dropped so the counter never wraps.
    assign ret_eff = credit_return_i & (credits_reg != '0);

    always_comb begin
        credits_next = credits_reg;
        if (launch && !ret_eff) begin
            credits_next = credits_reg + cred_w_lp'(1);
        end else if (!launch && ret_eff) begin
            credits_next = credits_reg - cred_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_reg <= '0;
            last_rd_reg <= 1'b1;
            hold_reg    <= 1'b0;
            hold_rd_reg <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            if (launch) begin
                last_rd_reg <= grant_rd;
            end
            hold_reg    <= out_v & ~out_ready_i;
            hold_rd_reg <= grant_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= DRLP_IDLE;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                DRLP_IDLE: begin
                    if (flush_i) begin
                        state_reg <= DRLP_DRAIN;
                    end else if (rd_v_i || wr_v_i || fifo_v) begin
                        state_reg <= DRLP_RUN;
                    end
                end
                DRLP_RUN: begin
                    if (flush_i) begin
                        state_reg <= DRLP_DRAIN;
                    end else if (fifo_empty && !rd_v_i && !wr_v_i && credits_reg == '0) begin
                        state_reg <= DRLP_IDLE;
                    end
                end
                DRLP_DRAIN: begin
                    // Looks at next-cycle credits so the final return completes the drain at once.
                    if (fifo_empty && credits_next == '0) begin
                        state_reg <= DRLP_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DRLP_DONE: begin
                    state_reg <= DRLP_IDLE;
                end
                default: begin
                    state_reg <= DRLP_IDLE;
                end
            endcase
        end
    end

    assign done_o    = done_reg;
    assign credits_o = credits_reg;

`ifdef DRLP_DMA_SCHED_STATS_EN
    logic [31:0] rd_cnt_reg, wr_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (launch && grant_rd) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if (launch && !grant_rd) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_reg;
    assign wr_cnt_o = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_drlp_dma_sched.sv
// Self-checking bench for drlp_dma_sched: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_drlp_dma_sched;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int MAXC  = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          reset, rd_v, rd_ready, wr_v, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr, out_addr;
    logic [DW-1:0] wr_data, out_data;
    logic          out_v, out_we, out_ready, credit_ret, flush, done;
    logic [CW-1:0] credits;
`ifdef DRLP_DMA_SCHED_STATS_EN
    logic [31:0]   rd_cnt, wr_cnt;
`endif

    always #5 clk = ~clk;

    drlp_dma_sched #(
        .data_width_p      (DW),
        .addr_width_p      (AW),
        .max_out_credits_p (MAXC),
        .wr_fifo_els_p     (DEPTH)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .rd_v_i          (rd_v),
        .rd_addr_i       (rd_addr),
        .rd_ready_o      (rd_ready),
        .wr_v_i          (wr_v),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_ready_o      (wr_ready),
        .out_v_o         (out_v),
        .out_we_o        (out_we),
        .out_addr_o      (out_addr),
        .out_data_o      (out_data),
        .out_ready_i     (out_ready),
        .credit_return_i (credit_ret),
        .flush_i         (flush),
        .done_o          (done),
        .credits_o       (credits)
`ifdef DRLP_DMA_SCHED_STATS_EN
        ,
        .rd_cnt_o        (rd_cnt),
        .wr_cnt_o        (wr_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic          rd_v;
        logic [AW-1:0] rd_addr;
        logic          wr_v;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          ordy;
        logic          cret;
        logic          e_v;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_rdr;
        logic          e_wrr;
        int            e_cred;
    } vec_t;

    function automatic vec_t mk(logic rv, int ra, logic wv, int wa, logic [DW-1:0] wd, logic ordy,
                                logic cret, logic ev, logic ewe, int ea, logic [DW-1:0] ed,
                                logic erdr, logic ewrr, int ecred);
        vec_t v;
        v.rd_v = rv;  v.rd_addr = AW'(ra); v.wr_v = wv; v.wr_addr = AW'(wa); v.wr_data = wd;
        v.ordy = ordy; v.cret = cret; v.e_v = ev; v.e_we = ewe; v.e_addr = AW'(ea); v.e_data = ed;
        v.e_rdr = erdr; v.e_wrr = ewrr; v.e_cred = ecred;
        return v;
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    vec_t    tbl [18];
    wr_ent_t wq [$];
    int      got_we [$];
    int      got_addr [$];
    int      got_data [$];
    int      wi, ri, launches, m_credits;
    logic    m_last_rd, m_prev_hold, m_prev_rd, m_rd_req, m_wr_req, m_side_rd;
    logic    m_out_v, m_launch, m_wr_ready, rd_pend, wr_pend;
    logic [AW-1:0] p_rd_addr, p_wr_addr;
    logic [DW-1:0] p_wr_data;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_v = 0; rd_addr = '0; wr_v = 0; wr_addr = '0; wr_data = '0;
        out_ready = 0; credit_ret = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        // ---- reset values ----
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        rd_v = 1; out_ready = 1;
        @(negedge clk);
        check("rst_out_v", out_v, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_done", done, 0);
        next_cycle();
        reset = 0;
        idle_inputs();
        @(negedge clk);
        check("post_rst_wr_ready", wr_ready, 1);
        check("post_rst_credits", credits, 0);
        check("post_rst_out_v", out_v, 0);
        next_cycle();
        do_reset();

        // ---- vector table: in-order stores, stalled store, credit return, a load ----
        tbl[0]  = mk(0,0,1,0,32'hA0,  1,0, 0,0,0,0,          0,1,0);
        tbl[1]  = mk(0,0,1,1,32'hA1,  1,0, 1,1,0,32'hA0,     0,1,0);
        tbl[2]  = mk(0,0,1,2,32'hA2,  1,0, 1,1,1,32'hA1,     0,1,1);
        tbl[3]  = mk(0,0,1,3,32'hA3,  1,0, 1,1,2,32'hA2,     0,1,2);
        tbl[4]  = mk(0,0,0,0,0,       1,0, 1,1,3,32'hA3,     0,1,3);
        tbl[5]  = mk(0,0,0,0,0,       1,0, 0,0,0,0,          0,1,4);
        tbl[6]  = mk(0,0,1,5,32'h1234,0,0, 0,0,0,0,          0,1,4);
        for (int i = 7; i < 12; i++) tbl[i] = mk(0,0,0,0,0, 0,0, 1,1,5,32'h1234, 0,1,4);
        tbl[12] = mk(0,0,0,0,0,       1,0, 1,1,5,32'h1234,   0,1,4);
        tbl[13] = mk(0,0,0,0,0,       1,0, 0,0,0,0,          0,1,5);
        tbl[14] = mk(0,0,0,0,0,       1,1, 0,0,0,0,          0,1,5);
        tbl[15] = mk(0,0,0,0,0,       1,0, 0,0,0,0,          0,1,4);
        tbl[16] = mk(1,6,0,0,0,       1,0, 1,0,6,0,          1,1,4);
        tbl[17] = mk(0,0,0,0,0,       1,0, 0,0,0,0,          0,1,5);
        for (int i = 0; i < 18; i++) begin
            rd_v = tbl[i].rd_v; rd_addr = tbl[i].rd_addr; wr_v = tbl[i].wr_v;
            wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
            out_ready = tbl[i].ordy; credit_ret = tbl[i].cret;
            @(negedge clk);
            check($sformatf("tbl%0d_out_v", i), out_v, tbl[i].e_v);
            if (tbl[i].e_v) begin
                check($sformatf("tbl%0d_we", i), out_we, tbl[i].e_we);
                check($sformatf("tbl%0d_addr", i), out_addr, tbl[i].e_addr);
                check($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
            end
            check($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].e_rdr);
            check($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].e_wrr);
            check($sformatf("tbl%0d_credits", i), credits, 64'(tbl[i].e_cred));
            next_cycle();
        end

        // ---- reads and writes competing: grants alternate W,R,... ----
        do_reset();
        wi = 0; ri = 0;
        got_we.delete(); got_addr.delete(); got_data.delete();
        for (int c = 0; c < 40 && got_we.size() < 8; c++) begin
            wr_v = (wi < 4); wr_addr = AW'(wi); wr_data = 32'hB0 + DW'(wi);
            rd_v = (c > 0) && (ri < 4); rd_addr = AW'(4 + ri); out_ready = 1;
            @(negedge clk);
            if (out_v && out_ready) begin
                got_we.push_back(int'(out_we));
                got_addr.push_back(int'(out_addr));
                got_data.push_back(int'(out_data));
            end
            if (wr_v && wr_ready) wi++;
            if (rd_v && rd_ready) ri++;
            next_cycle();
        end
        idle_inputs();
        check("alt_launch_count", got_we.size(), 8);
        for (int k = 0; k < got_we.size() && k < 8; k++) begin
            check($sformatf("alt%0d_we", k), got_we[k], (k % 2 == 0) ? 1 : 0);
            check($sformatf("alt%0d_addr", k), got_addr[k], (k % 2 == 0) ? k / 2 : 4 + k / 2);
            if (k % 2 == 0) check($sformatf("alt%0d_data", k), got_data[k], 32'hB0 + k / 2);
        end

        // ---- credit ceiling: 20 reads, no returns, then one launch per return ----
        do_reset();
        launches = 0;
        rd_v = 1; rd_addr = 2; out_ready = 1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (rd_ready) launches++;
            next_cycle();
        end
        check("sat_launches", launches, 16);
        check("sat_credits", credits, 16);
        for (int k = 0; k < 4; k++) begin
            credit_ret = 1;
            @(negedge clk);
            check($sformatf("sat_ret%0d_out_v", k), out_v, 0);
            if (rd_ready) launches++;
            next_cycle();
            credit_ret = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (rd_ready) launches++;
                next_cycle();
            end
            check($sformatf("sat_ret%0d_launches", k), launches, 17 + k);
        end
        idle_inputs();

        // ---- flush with 2 buffered writes and 3 outstanding ----
        do_reset();
        rd_v = 1; out_ready = 1;
        repeat (3) next_cycle();
        rd_v = 0; out_ready = 0;
        wr_v = 1; wr_addr = 1; wr_data = 32'hC1; next_cycle();
        wr_addr = 2; wr_data = 32'hC2; next_cycle();
        wr_v = 0; flush = 1;
        @(negedge clk);
        check("fl_credits_pre", credits, 3);
        next_cycle();
        flush = 0;
        rd_v = 1; rd_addr = 7; wr_v = 1; wr_addr = 3; wr_data = 32'hC3; out_ready = 1;
        @(negedge clk);
        check("fl_d1_rd_ready", rd_ready, 0);
        check("fl_d1_wr_ready", wr_ready, 0);
        check("fl_d1_out_v", out_v, 1);
        check("fl_d1_we", out_we, 1);
        check("fl_d1_addr", out_addr, 1);
        next_cycle();
        @(negedge clk);
        check("fl_d2_rd_ready", rd_ready, 0);
        check("fl_d2_we", out_we, 1);
        check("fl_d2_addr", out_addr, 2);
        next_cycle();
        @(negedge clk);
        check("fl_d3_out_v", out_v, 0);
        check("fl_d3_credits", credits, 5);
        next_cycle();
        rd_v = 0; wr_v = 0;
        for (int k = 0; k < 5; k++) begin
            credit_ret = 1; flush = (k == 0);
            @(negedge clk);
            check($sformatf("fl_ret%0d_done", k), done, 0);
            next_cycle();
        end
        credit_ret = 0; flush = 0;
        @(negedge clk);
        check("fl_done_pulse", done, 1);
        check("fl_done_credits", credits, 0);
        next_cycle();
        @(negedge clk);
        check("fl_done_clear", done, 0);
        next_cycle();

        // ---- reset with buffered writes and an outstanding load ----
        do_reset();
        rd_v = 1; out_ready = 1; next_cycle();
        rd_v = 0; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            wr_v = 1; wr_addr = AW'(i); wr_data = 32'hD0 + DW'(i); next_cycle();
        end
        wr_v = 0; reset = 1; out_ready = 1;
        @(negedge clk);
        check("mid_rst_out_v", out_v, 0);
        next_cycle();
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            credit_ret = (c == 0);
            @(negedge clk);
            check($sformatf("mid_rst%0d_out_v", c), out_v, 0);
            check($sformatf("mid_rst%0d_credits", c), credits, 0);
            check($sformatf("mid_rst%0d_wr_ready", c), wr_ready, 1);
            next_cycle();
        end
        idle_inputs();

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        wq.delete();
        m_credits = 0; m_last_rd = 1; m_prev_hold = 0; m_prev_rd = 0;
        rd_pend = 0; wr_pend = 0; p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!rd_pend && $urandom_range(0, 99) < 40) begin
                rd_pend = 1; p_rd_addr = AW'($urandom);
            end
            if (!wr_pend && $urandom_range(0, 99) < 50) begin
                wr_pend = 1; p_wr_addr = AW'($urandom); p_wr_data = $urandom;
            end
            rd_v = rd_pend; rd_addr = p_rd_addr;
            wr_v = wr_pend; wr_addr = p_wr_addr; wr_data = p_wr_data;
            out_ready = ($urandom_range(0, 99) < 70);
            credit_ret = ($urandom_range(0, 99) < 25);
            @(negedge clk);
            m_rd_req = rd_pend;
            m_wr_req = (wq.size() > 0);
            // A stalled packet stays presented while its source still has it; else alternate.
            if (m_prev_hold && (m_prev_rd ? m_rd_req : m_wr_req)) m_side_rd = m_prev_rd;
            else if (m_rd_req && m_wr_req) m_side_rd = !m_last_rd;
            else m_side_rd = m_rd_req;
            m_out_v    = (m_rd_req || m_wr_req) && (m_credits < MAXC);
            m_launch   = m_out_v && out_ready;
            m_wr_ready = (wq.size() < DEPTH) || (m_launch && !m_side_rd);
            check($sformatf("rnd%0d_out_v", cyc), out_v, m_out_v);
            if (m_out_v) begin
                check($sformatf("rnd%0d_we", cyc), out_we, !m_side_rd);
                check($sformatf("rnd%0d_addr", cyc), out_addr, m_side_rd ? p_rd_addr : wq[0].addr);
                check($sformatf("rnd%0d_data", cyc), out_data, m_side_rd ? '0 : wq[0].data);
            end
            check($sformatf("rnd%0d_rd_ready", cyc), rd_ready, m_launch && m_side_rd);
            check($sformatf("rnd%0d_wr_ready", cyc), wr_ready, m_wr_ready);
            check($sformatf("rnd%0d_credits", cyc), credits, 64'(m_credits));
            if (m_launch && !m_side_rd) void'(wq.pop_front());
            if (wr_pend && m_wr_ready) begin
                wr_ent_t e;
                e.addr = p_wr_addr; e.data = p_wr_data;
                wq.push_back(e);
                wr_pend = 0;
            end
            if (m_launch && m_side_rd) rd_pend = 0;
            if (credit_ret && m_credits > 0) m_credits--;
            if (m_launch) begin
                m_credits++;
                m_last_rd = m_side_rd;
            end
            m_prev_hold = m_out_v && !out_ready;
            m_prev_rd   = m_side_rd;
            next_cycle();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drlp_dma_sched.md
DRLP_DMA_SCHED -- requirements
Module: drlp_dma_sched

Interface
REQ-001 SHALL have parameter data_width_p, default 32: DMA data width.
REQ-002 SHALL have parameter addr_width_p, default 3: DMA word address width.
REQ-003 SHALL have parameter max_out_credits_p, default 16: maximum outstanding network requests.
REQ-004 SHALL have parameter wr_fifo_els_p, default 4: write-buffer depth (power of 2, >=2).
REQ-005 SHALL have ports, in order:
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- rd_v_i  in  1  DRLP read request valid.
- rd_addr_i  in  addr_width_p  read address.
- rd_ready_o  out  1  read request accepted when rd_v_i&rd_ready_o.
- wr_v_i  in  1  DRLP write request valid.
- wr_addr_i  in  addr_width_p  write address.
- wr_data_i  in  data_width_p  write data.
- wr_ready_o  out  1  write buffer not full.
- out_v_o  out  1  packet valid to endpoint.
- out_we_o  out  1  1=remote store, 0=remote load.
- out_addr_o  out  addr_width_p  packet address.
- out_data_o  out  data_width_p  packet data (0 for loads).
- out_ready_i  in  1  endpoint accepts when out_v_o&out_ready_i.
- credit_return_i  in  1  one outstanding request completed.
- flush_i  in  1  pulse: drain all traffic.
- done_o  out  1  one-cycle pulse: flush complete.
- credits_o  out  $clog2(max_out_credits_p+1)  outstanding count.

Function
REQ-006 SHALL accept writes into a FIFO of wr_fifo_els_p entries; wr_ready_o=~full; push and pop in the same cycle SHALL be allowed when full.
REQ-007 SHALL accept a read only when it is granted and launched that cycle (rd_ready_o=grant_rd&out_ready_i&credit_avail); reads are never buffered.
REQ-008 SHALL arbitrate round-robin between read and FIFO-head write; last-granted side loses a tie; after reset write has priority.
REQ-009 SHALL present out_v_o combinationally from the granted source; fields SHALL stay stable while out_v_o&~out_ready_i.
REQ-010 SHALL assert out_v_o only when credits_o<max_out_credits_p.
REQ-011 Credit counter SHALL +1 on launch, -1 on credit_return_i, unchanged when both occur; credit_return_i at zero SHALL be ignored (saturate, no wrap).
REQ-012 FSM states: IDLE (no traffic), RUN, DRAIN, DONE. IDLE->RUN on any valid; RUN->IDLE when FIFO empty, no rd_v_i, credits 0.
REQ-013 flush_i in IDLE/RUN SHALL enter DRAIN; in DRAIN rd_ready_o=0, wr_ready_o=0, buffered writes still issue.
REQ-014 DRAIN->DONE when FIFO empty and credits 0 (including the cycle the last credit returns); DONE SHALL pulse done_o one cycle then go IDLE.
REQ-015 flush_i in DRAIN/DONE SHALL be ignored.

Reset
REQ-016 On reset_i: FIFO empty, credits 0, state IDLE, write priority, out_v_o=0, done_o=0, rd_ready_o=0; wr_ready_o=1 from first cycle after reset.
REQ-017 Reset mid-transfer SHALL discard buffered writes and outstanding credits without issuing packets.

Configuration
REQ-018 With DRLP_DMA_SCHED_STATS_EN defined, SHALL add outputs rd_cnt_o and wr_cnt_o (32 b each), counting launched loads/stores, wrapping at 2^32, cleared by reset.
REQ-019 Without DRLP_DMA_SCHED_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-020 Package drlp_pkg SHALL hold the FSM state enum (drlp_dma_state_e) and the request struct {we, addr, data}.
REQ-021 Write buffer SHALL be sub-module drlp_dma_wr_fifo (1R1W, valid/ready, full/empty).

Verification
REQ-022 Four writes (addr 0..3, data 0xA0..0xA3), out_ready_i=1 -> four stores in order, credits_o=4, wr_ready_o never drops.
REQ-023 rd_v_i and wr_v_i held together, 4 each -> grants alternate W,R,W,R...; FIFO order preserved.
REQ-024 max_out_credits_p=16, no credit_return_i, 20 reads -> 16 launches, then out_v_o=0 until credit returns; one launch per return.
REQ-025 out_ready_i=0 for 5 cycles with pending store addr 5 data 0x1234 -> fields stable all 5 cycles, single launch.
REQ-026 2 writes buffered, 3 outstanding, flush_i -> writes issue, rd_ready_o=0; done_o pulses one cycle after fifth credit_return_i.
REQ-027 reset_i with 3 buffered writes -> no packets issued, credits_o=0, state IDLE.
